mem_txn_ctrl: RTL

//  Memory transaction controller between the shared-memory arbiter's mem_* port and a memory

---
 rtl/mem_txn_ctrl_if.sv | 27 ++
 rtl/mem_txn_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mem_txn_ctrl_if.sv
// Upstream (arbiter <-> controller) and downstream (controller <-> memory) bus bundles.
// The controller is the slave of the upstream bundle and the master of the downstream one.
interface mem_txn_up_if;
  logic        req;
  logic        we;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic        valid;
  logic [63:0] rdata;
  logic        busy;

  modport master (output req, we, addr, wdata, input valid, rdata, busy);
  modport slave  (input req, we, addr, wdata, output valid, rdata, busy);
endinterface

interface mem_txn_dn_if;
  logic        req;
  logic        we;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic        ready;
  logic        rvalid;
  logic [63:0] rdata;

  modport master (output req, we, addr, wdata, input ready, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output ready, rvalid, rdata);
endinterface

// File: rtl/mem_txn_ctrl.sv
// Memory transaction controller: queues upstream requests, issues them downstream with a held
// req/ready handshake, caps in-flight work and answers in order. MEM_TIMEOUT_EN adds a watchdog.
module mem_txn_ctrl #(
  parameter int unsigned CMD_DEPTH = 32,
  parameter int unsigned MAX_OUT   = 8,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic                         clk,
  input  logic                         rst_n,
  mem_txn_up_if.slave                  up,
  mem_txn_dn_if.master                 dn,
  output logic [$clog2(MAX_OUT+1)-1:0] out_cnt_o,
  output logic                         err_ovf_o,
  output logic                         err_proto_o,
  output logic                         err_tmo_o
);

  localparam int unsigned CmdAw = $clog2(CMD_DEPTH);
  localparam int unsigned OrdAw = $clog2(MAX_OUT);
  localparam int unsigned OutW  = $clog2(MAX_OUT + 1);

  typedef logic [CmdAw:0]   cmd_ptr_t;
  typedef logic [OrdAw-1:0] ord_ptr_t;
  typedef logic [OutW-1:0]  cnt_t;

  localparam cmd_ptr_t CmdFull = cmd_ptr_t'(CMD_DEPTH);
  localparam cmd_ptr_t CmdBusy = cmd_ptr_t'(CMD_DEPTH - 2);
  localparam cnt_t     MaxOut  = cnt_t'(MAX_OUT);

  typedef struct packed {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {StIdle, StIssue, StStall} state_e;

  // Command queue
  cmd_t     cmd_mem [CMD_DEPTH];
  cmd_ptr_t cmd_wr_q, cmd_rd_q, cmd_cnt;
  cmd_t     cmd_in, cmd_head;
  logic     cmd_empty, cmd_full, cmd_avail, cmd_push, cmd_pop;

  // Issue FSM
  state_e st_q, st_d;
  logic   dn_req_q, dn_req_d;
  cmd_t   dn_cmd_q, dn_cmd_d;
  logic   accept, accept_rd;
  cnt_t   out_cnt_q, out_cnt_inc;

  // Ordering and read-data FIFOs
  logic [MAX_OUT-1:0] ord_mem;
  ord_ptr_t           ord_wr_q, ord_rd_q;
  logic [63:0]        rd_mem [MAX_OUT];
  ord_ptr_t           rd_wr_q, rd_rd_q;
  cnt_t               rd_cnt_q, rd_inflight_q;
  logic               head_we, resp_pop, rd_pop, rd_push, proto_err;

  logic        up_valid_q;
  logic [63:0] up_rdata_q;
  logic        err_ovf_q, err_proto_q;

  assign cmd_cnt   = cmd_wr_q - cmd_rd_q;
  assign cmd_empty = (cmd_cnt == '0);
  assign cmd_full  = (cmd_cnt == CmdFull);
  assign cmd_in    = '{we: up.we, addr: up.addr, wdata: up.wdata};
  // An empty queue lets the incoming request go straight to the issue register.
  assign cmd_avail = !cmd_empty || up.req;
  assign cmd_head  = cmd_empty ? cmd_in : cmd_mem[cmd_rd_q[CmdAw-1:0]];
  assign cmd_push  = up.req && !cmd_full && !(cmd_empty && cmd_pop);

  assign accept      = dn_req_q && dn.ready;
  assign accept_rd   = accept && !dn_cmd_q.we;
  assign out_cnt_inc = out_cnt_q + cnt_t'(1);

  always_comb begin
    st_d     = st_q;
    dn_req_d = dn_req_q;
    dn_cmd_d = dn_cmd_q;
    cmd_pop  = 1'b0;
    unique case (st_q)
      StIdle: begin
        if (cmd_avail) begin
          if (out_cnt_q < MaxOut) begin
            cmd_pop  = 1'b1;
            dn_cmd_d = cmd_head;
            dn_req_d = 1'b1;
            st_d     = StIssue;
          end else begin
            st_d = StStall;
          end
        end
      end
      StIssue: begin
        if (accept) begin
          if (cmd_avail && (out_cnt_inc < MaxOut)) begin
            cmd_pop  = 1'b1;
            dn_cmd_d = cmd_head;
          end else begin
            dn_req_d = 1'b0;
            st_d     = (out_cnt_inc < MaxOut) ? StIdle : StStall;
          end
        end
      end
      StStall: begin
        if (out_cnt_q < MaxOut) st_d = StIdle;
      end
      default: st_d = StIdle;
    endcase
  end

  assign head_we   = ord_mem[ord_rd_q];
  assign resp_pop  = (out_cnt_q != '0) && (head_we || (rd_cnt_q != '0));
  assign rd_pop    = resp_pop && !head_we;
  assign rd_push   = dn.rvalid && (rd_inflight_q != '0);
  assign proto_err = dn.rvalid && (rd_inflight_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_wr_q      <= '0;
      cmd_rd_q      <= '0;
      st_q          <= StIdle;
      dn_req_q      <= 1'b0;
      dn_cmd_q      <= '0;
      out_cnt_q     <= '0;
      ord_wr_q      <= '0;
      ord_rd_q      <= '0;
      rd_wr_q       <= '0;
      rd_rd_q       <= '0;
      rd_cnt_q      <= '0;
      rd_inflight_q <= '0;
      up_valid_q    <= 1'b0;
      up_rdata_q    <= '0;
      err_ovf_q     <= 1'b0;
      err_proto_q   <= 1'b0;
    end else begin
      st_q     <= st_d;
      dn_req_q <= dn_req_d;
      dn_cmd_q <= dn_cmd_d;
      if (cmd_push)               cmd_wr_q <= cmd_wr_q + cmd_ptr_t'(1);
      if (cmd_pop && !cmd_empty)  cmd_rd_q <= cmd_rd_q + cmd_ptr_t'(1);
      if (accept)                 ord_wr_q <= ord_wr_q + ord_ptr_t'(1);
      if (resp_pop)               ord_rd_q <= ord_rd_q + ord_ptr_t'(1);
      if (rd_push)                rd_wr_q  <= rd_wr_q + ord_ptr_t'(1);
      if (rd_pop)                 rd_rd_q  <= rd_rd_q + ord_ptr_t'(1);
      out_cnt_q     <= out_cnt_q + cnt_t'(accept) - cnt_t'(resp_pop);
      rd_cnt_q      <= rd_cnt_q + cnt_t'(rd_push) - cnt_t'(rd_pop);
      rd_inflight_q <= rd_inflight_q + cnt_t'(accept_rd) - cnt_t'(rd_push);
      up_valid_q    <= resp_pop;
      if (resp_pop) up_rdata_q <= head_we ? 64'h0 : rd_mem[rd_rd_q];
      if (up.req && cmd_full) err_ovf_q <= 1'b1;
      if (proto_err)          err_proto_q <= 1'b1;
    end
  end

  // Storage arrays carry no reset; pointers alone define their contents.
  always_ff @(posedge clk) begin
    if (cmd_push) cmd_mem[cmd_wr_q[CmdAw-1:0]] <= cmd_in;
    if (accept)   ord_mem[ord_wr_q] <= dn_cmd_q.we;
    if (rd_push)  rd_mem[rd_wr_q] <= dn.rdata;
  end

`ifdef MEM_TIMEOUT_EN
  logic [31:0] tmo_cnt_q;
  logic        err_tmo_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
      err_tmo_q <= 1'b0;
    end else begin
      if ((rd_inflight_q == '0) || dn.rvalid) begin
        tmo_cnt_q <= '0;
      end else if (tmo_cnt_q != TIMEOUT) begin
        tmo_cnt_q <= tmo_cnt_q + 32'd1;
      end
      if (tmo_cnt_q == TIMEOUT) err_tmo_q <= 1'b1;
    end
  end

  assign err_tmo_o = err_tmo_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign err_tmo_o      = 1'b0;
`endif

  assign dn.req      = dn_req_q;
  assign dn.we       = dn_cmd_q.we;
  assign dn.addr     = dn_cmd_q.addr;
  assign dn.wdata    = dn_cmd_q.wdata;
  assign up.valid    = up_valid_q;
  assign up.rdata    = up_rdata_q;
  assign up.busy     = (cmd_cnt >= CmdBusy);
  assign out_cnt_o   = out_cnt_q;
  assign err_ovf_o   = err_ovf_q;
  assign err_proto_o = err_proto_q;

endmodule
